// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: widths, memory op codes,
// FSM states and op-decoding helpers.
package mem_stage_pkg;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LH   = 4'd2;
  localparam logic [3:0] MEM_LW   = 4'd3;
  localparam logic [3:0] MEM_LBU  = 4'd4;
  localparam logic [3:0] MEM_LHU  = 4'd5;
  localparam logic [3:0] MEM_SB   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SW   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic logic op_is_load(logic [3:0] op);
    return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
  endfunction

  function automatic logic op_is_store(logic [3:0] op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic logic [2:0] op_bytes(logic [3:0] op);
    logic [2:0] n;
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: n = 3'd1;
      MEM_LH, MEM_LHU, MEM_SH: n = 3'd2;
      MEM_LW, MEM_SW:          n = 3'd4;
      default:                 n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic op_misaligned(logic [3:0] op,
                                         logic [1:0] a);
    logic m;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: m = a[0];
      MEM_LW, MEM_SW:          m = |a;
      default:                 m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Width/sign extension of the assembled load buffer, selected by op.
module mem_stage_load_ext
  import mem_stage_pkg::*;
(
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_buf,
  output logic [XLEN-1:0] o_data
);

  always_comb begin
    o_data = i_buf;
    unique case (i_op)
      MEM_LB:  o_data = {{24{i_buf[7]}}, i_buf[7:0]};
      MEM_LBU: o_data = {24'd0, i_buf[7:0]};
      MEM_LH:  o_data = {{16{i_buf[15]}}, i_buf[15:0]};
      MEM_LHU: o_data = {16'd0, i_buf[15:0]};
      default: o_data = i_buf;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: byte-serial loads/stores on an 8-bit port.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   rd_data_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              rd_enable_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [XLEN-1:0]   store_data_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [7:0]        mem_dout_o,
  input  logic [7:0]        mem_din_i,
  input  logic              mem_ready_i,
  output logic              stall_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic [4:0]        rd_addr_o,
  output logic              rd_enable_o,
  output logic              misalign_o
);

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_idx;
  logic [XLEN-1:0] r_buf;

  logic            w_load;
  logic            w_store;
  logic            w_mem;
  logic            w_last;
  logic            w_trap;
  logic [2:0]      w_bytes;
  logic [XLEN-1:0] w_ext;

  assign w_load  = op_is_load(mem_op_i);
  assign w_store = op_is_store(mem_op_i);
  assign w_mem   = w_load | w_store;
  assign w_bytes = op_bytes(mem_op_i);
  assign w_last  = ({1'b0, r_idx} == (w_bytes - 3'd1));

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_trap = op_misaligned(mem_op_i, mem_addr_i[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  mem_stage_load_ext u_load_ext (
    .i_op   (mem_op_i),
    .i_buf  (r_buf),
    .o_data (w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_mem) w_next = w_trap ? ST_DONE : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!w_mem)
          w_next = ST_IDLE;
        else if (mem_ready_i && w_last)
          w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // buffer is cleared per op so short loads never see stale bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= 2'd0;
      r_buf <= '0;
    end else if (r_state == ST_ACCESS) begin
      if (mem_ready_i) begin
        r_idx <= r_idx + 2'd1;
        if (w_load) r_buf[{r_idx, 3'b000} +: 8] <= mem_din_i;
      end
    end else begin
      r_idx <= 2'd0;
      if (r_state == ST_IDLE) r_buf <= '0;
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_a_o     = '0;
    mem_dout_o  = 8'd0;
    stall_o     = 1'b0;
    rd_data_o   = '0;
    rd_addr_o   = 5'd0;
    rd_enable_o = 1'b0;
    misalign_o  = 1'b0;
    if (!rst) begin
      rd_addr_o = rd_addr_i;
      if (!w_mem) begin
        rd_data_o   = rd_data_i;
        rd_enable_o = rd_enable_i;
      end else begin
        unique case (r_state)
          ST_IDLE: stall_o = 1'b1;
          ST_ACCESS: begin
            stall_o    = 1'b1;
            mem_req_o  = 1'b1;
            mem_we_o   = w_store;
            mem_a_o    = mem_addr_i
                       + {{(ADDR_W-2){1'b0}}, r_idx};
            mem_dout_o = store_data_i[{r_idx, 3'b000} +: 8];
          end
          ST_DONE: begin
            misalign_o = w_trap;
            if (w_load && !w_trap) begin
              rd_data_o   = w_ext;
              rd_enable_o = rd_enable_i;
            end
          end
          default: stall_o = 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: random and directed ops against a
// byte-addressed reference memory model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [XLEN-1:0]   rd_data_i = '0;
  logic [4:0]        rd_addr_i = '0;
  logic              rd_enable_i = 1'b0;
  logic [3:0]        mem_op_i = MEM_NONE;
  logic [ADDR_W-1:0] mem_addr_i = '0;
  logic [XLEN-1:0]   store_data_i = '0;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_a_o;
  logic [7:0]        mem_dout_o;
  logic [7:0]        mem_din_i = 8'd0;
  logic              mem_ready_i = 1'b0;
  logic              stall_o;
  logic [XLEN-1:0]   rd_data_o;
  logic [4:0]        rd_addr_o;
  logic              rd_enable_o;
  logic              misalign_o;

  mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .rd_data_i    (rd_data_i),
    .rd_addr_i    (rd_addr_i),
    .rd_enable_i  (rd_enable_i),
    .mem_op_i     (mem_op_i),
    .mem_addr_i   (mem_addr_i),
    .store_data_i (store_data_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_a_o      (mem_a_o),
    .mem_dout_o   (mem_dout_o),
    .mem_din_i    (mem_din_i),
    .mem_ready_i  (mem_ready_i),
    .stall_o      (stall_o),
    .rd_data_o    (rd_data_o),
    .rd_addr_o    (rd_addr_o),
    .rd_enable_o  (rd_enable_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        en;
    logic        mis;
    int          stall;
    logic        chk_data;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [7:0]  d;
  } byte_t;

  exp_t  sb[$];
  byte_t bq[$];
  logic [7:0] ref_mem [bit [31:0]];
  logic [7:0] dev_mem [bit [31:0]];

  int   n_chk = 0;
  int   n_fail = 0;
  int   n_retired = 0;
  int   stall_cnt = 0;
  int   wait_mode = 0;
  logic tb_valid = 1'b0;

  function automatic logic [7:0] init_byte(logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] dev_rd(logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_byte(a);
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(logic [31:0] a, logic [7:0] d);
    ref_mem[a] = d;
    dev_mem[a] = d;
  endtask

  // monitor: one retirement per non-stalled cycle of a presented op
  always @(negedge clk) begin
    exp_t e;
    if (!rst && tb_valid) begin
      if (stall_o) begin
        stall_cnt++;
      end else begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_empty: got retire expected none");
        end else begin
          e = sb.pop_front();
          chk("rd_addr", 32'(rd_addr_o), 32'(e.addr));
          chk("rd_enable", 32'(rd_enable_o), 32'(e.en));
          chk("misalign", 32'(misalign_o), 32'(e.mis));
          if (e.chk_data) chk("rd_data", rd_data_o, e.data);
          if (e.stall >= 0)
            chk("stall_cycles", stall_cnt, e.stall);
        end
        stall_cnt = 0;
        n_retired++;
      end
    end
  end

  // memory responder with optional wait states
  int          waits_left = 0;
  logic        in_byte = 1'b0;
  logic [31:0] byte_a;
  logic [7:0]  byte_d;
  always @(negedge clk) begin
    byte_t b;
    mem_ready_i = 1'b0;
    if (mem_req_o) begin
      if (!in_byte) begin
        in_byte = 1'b1;
        byte_a = mem_a_o;
        byte_d = mem_dout_o;
        waits_left = (wait_mode < 0) ? int'($urandom_range(0, 2))
                                     : wait_mode;
      end else begin
        chk("addr_stable", mem_a_o, byte_a);
        chk("dout_stable", 32'(mem_dout_o), 32'(byte_d));
      end
      if (waits_left == 0) begin
        in_byte = 1'b0;
        mem_ready_i = 1'b1;
        mem_din_i = dev_rd(mem_a_o);
        if (bq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_req: got addr %h expected none",
                   mem_a_o);
        end else begin
          b = bq.pop_front();
          chk("mem_a", mem_a_o, b.a);
          chk("mem_we", 32'(mem_we_o), 32'(b.we));
          if (b.we) chk("mem_dout", 32'(mem_dout_o), 32'(b.d));
        end
        if (mem_we_o) dev_mem[mem_a_o] = mem_dout_o;
      end else begin
        waits_left--;
        mem_din_i = 8'($urandom);
      end
    end else begin
      in_byte = 1'b0;
      mem_din_i = 8'($urandom);
    end
  end

  task automatic issue(logic [3:0] op, logic [31:0] a,
                       logic [31:0] sd, logic [4:0] rd,
                       logic en, logic [31:0] alu);
    exp_t   e;
    byte_t  b;
    int     n;
    int     start;
    int     cyc;
    logic   ld;
    logic   st;
    logic   mis;
    longint v;
    ld = op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    st = op inside {MEM_SB, MEM_SH, MEM_SW};
    n = (op inside {MEM_LB, MEM_LBU, MEM_SB}) ? 1 :
        (op inside {MEM_LH, MEM_LHU, MEM_SH}) ? 2 :
        (op inside {MEM_LW, MEM_SW}) ? 4 : 0;
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (n == 2 && (a % 2) != 0) || (n == 4 && (a % 4) != 0);
`endif
    e.addr = rd;
    e.mis = mis;
    e.chk_data = 1'b1;
    if (!ld && !st) begin
      e.data = alu;
      e.en = en;
      e.stall = 0;
    end else begin
      e.stall = (wait_mode == 0) ? (mis ? 1 : 1 + n) : -1;
      if (mis) begin
        e.data = 32'd0;
        e.en = 1'b0;
        e.chk_data = st;
      end else if (st) begin
        e.data = 32'd0;
        e.en = 1'b0;
        for (int k = 0; k < n; k++) begin
          b.a = a + 32'(k);
          b.we = 1'b1;
          b.d = sd[8*k +: 8];
          bq.push_back(b);
          ref_mem[b.a] = b.d;
        end
      end else begin
        v = 0;
        for (int k = 0; k < n; k++) begin
          b.a = a + 32'(k);
          b.we = 1'b0;
          b.d = 8'd0;
          bq.push_back(b);
          v = v + (longint'(ref_rd(b.a)) << (8 * k));
        end
        if ((op == MEM_LB || op == MEM_LH) && v[8*n-1])
          v = v - (longint'(1) << (8 * n));
        e.data = v[31:0];
        e.en = en;
      end
    end
    sb.push_back(e);
    mem_op_i = op;
    mem_addr_i = a;
    store_data_i = sd;
    rd_addr_i = rd;
    rd_enable_i = en;
    rd_data_i = alu;
    tb_valid = 1'b1;
    start = n_retired;
    cyc = 0;
    while (n_retired == start && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    if (n_retired == start) begin
      n_fail++;
      $display("FAIL timeout: got no retire expected op %0d", op);
      $fatal(1, "timeout");
    end
    #1;
  endtask

  task automatic go_idle();
    mem_op_i = MEM_NONE;
    tb_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rd_data_i = 32'hDEAD_BEEF;
    rd_addr_i = 5'd7;
    rd_enable_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_data", rd_data_o, 32'd0);
    chk("rst_rd_addr", 32'(rd_addr_o), 32'd0);
    chk("rst_rd_en", 32'(rd_enable_o), 32'd0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_a", mem_a_o, 32'd0);
    chk("rst_dout", 32'(mem_dout_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    wait_mode = 0;
    issue(MEM_NONE, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0000_1234);
    preload(32'h100, 8'h78);
    preload(32'h101, 8'h56);
    preload(32'h102, 8'h34);
    preload(32'h103, 8'h12);
    issue(MEM_LW, 32'h100, 32'h0, 5'd3, 1'b1, 32'h0);
    preload(32'h200, 8'h80);
    issue(MEM_LB, 32'h200, 32'h0, 5'd4, 1'b1, 32'h0);
    issue(MEM_LBU, 32'h200, 32'h0, 5'd4, 1'b1, 32'h0);
    preload(32'h210, 8'h34);
    preload(32'h211, 8'hF2);
    issue(MEM_LH, 32'h210, 32'h0, 5'd8, 1'b1, 32'h0);
    issue(MEM_LHU, 32'h210, 32'h0, 5'd8, 1'b1, 32'h0);

    wait_mode = 2;
    issue(MEM_SH, 32'h300, 32'hAABB_CCDD, 5'd6, 1'b1, 32'h55);
    chk("sh_byte0", 32'(dev_rd(32'h300)), 32'hDD);
    chk("sh_byte1", 32'(dev_rd(32'h301)), 32'hCC);
    wait_mode = 0;

    issue(MEM_LW, 32'h102, 32'h0, 5'd2, 1'b1, 32'h0);
    issue(MEM_SW, 32'h106, 32'h1122_3344, 5'd2, 1'b1, 32'h0);
    issue(4'hC, 32'h0, 32'h0, 5'd9, 1'b1, 32'hCAFE_F00D);

    // reset during second byte of a load
    go_idle();
    bq.push_back('{a: 32'h400, we: 1'b0, d: 8'h00});
    mem_op_i = MEM_LW;
    mem_addr_i = 32'h400;
    rd_addr_i = 5'd9;
    rd_enable_i = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_req", 32'(mem_req_o), 32'd0);
    chk("rstmid_stall", 32'(stall_o), 32'd0);
    chk("rstmid_rd_en", 32'(rd_enable_o), 32'd0);
    mem_op_i = MEM_NONE;
    rd_enable_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_idle_stall", 32'(stall_o), 32'd0);
    chk("rstmid_bytes", bq.size(), 32'd0);
    @(posedge clk);
    #1;
    issue(MEM_LW, 32'h100, 32'h0, 5'd3, 1'b1, 32'h0);

    wait_mode = -1;
    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom_range(0, 10)),
            32'h1000 + 32'($urandom_range(0, 63)),
            $urandom, 5'($urandom), 1'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();
    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    chk("bq_drained", bq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
